// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: 4x4 register file, IDLE/EXEC/WB sequencing,
// operand/opcode registers to an external ALU, result write-back and flags.
module alu_issue_ctrl #(
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [3:0] ALU_In1,
  output logic [3:0] ALU_In2,
  output logic [1:0] Opcode,
  input  logic [3:0] ALU_Out,
  input  logic       Error,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [3:0] ld_data,
  input  logic [1:0] rd_addr,
  output logic [3:0] rd_data,
  output logic       done,
  output logic       z_flag,
  output logic       ovf_flag,
  input  logic       clr_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_e;

  state_e     state_q;
  logic [3:0] rf_q [4];
  logic [3:0] rf_d [4];
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] op_q;
  logic [1:0] rd_q;
  logic [3:0] result_q;
  logic       done_q;
  logic       z_q;
  logic       ovf_q;

  logic [1:0] rs;
  logic [1:0] rt;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       err_d;

  assign rs = instr[3:2];
  assign rt = instr[1:0];

  assign op_a = (ZERO_R0 && rs == 2'd0) ? 4'h0 : rf_q[rs];
  assign op_b = (ZERO_R0 && rt == 2'd0) ? 4'h0 : rf_q[rt];

  assign rd_data = (ZERO_R0 && rd_addr == 2'd0) ? 4'h0 : rf_q[rd_addr];

  // Overflow only has meaning for add/sub (Opcode[1] == 0).
  assign err_d = Error & ~op_q[1];

  assign instr_ready = (state_q == IDLE);
  assign ALU_In1     = a_q;
  assign ALU_In2     = b_q;
  assign Opcode      = op_q;
  assign done        = done_q;
  assign z_flag      = z_q;
  assign ovf_flag    = ovf_q;

  // Write-back is applied after the load port so it wins a collision.
  always_comb begin
    rf_d = rf_q;
    if (ld_en) rf_d[ld_addr] = ld_data;
    if (state_q == WB) rf_d[rd_q] = result_q;
    if (ZERO_R0) rf_d[0] = 4'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) rf_q[i] <= 4'h0;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      op_q     <= 2'd0;
      rd_q     <= 2'd0;
      result_q <= 4'h0;
      done_q   <= 1'b0;
      z_q      <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rf_q   <= rf_d;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (instr_valid) begin
            op_q    <= instr[7:6];
            rd_q    <= instr[5:4];
            a_q     <= op_a;
            b_q     <= op_b;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q <= ALU_Out;
          done_q   <= 1'b1;
          state_q  <= WB;
        end
        WB: begin
          z_q     <= (result_q == 4'h0);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (state_q == EXEC && err_d) ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter ZERO_R0, default 1: when 1, register r0 reads as 4'h0 and writes to it are discarded.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port instr_valid, input, 1: an instruction is offered.
REQ-005 SHALL have port instr, input, 8: [7:6] op, [5:4] rd, [3:2] rs, [1:0] rt.
REQ-006 SHALL have port instr_ready, output, 1: high only in IDLE.
REQ-007 SHALL have port ALU_In1, output, 4: operand A to the ALU, driven from a register.
REQ-008 SHALL have port ALU_In2, output, 4: operand B to the ALU, driven from a register.
REQ-009 SHALL have port Opcode, output, 2: ALU op (00 add, 01 sub, 10 nand, 11 xor), driven from a register.
REQ-010 SHALL have port ALU_Out, input, 4: ALU result, combinational from the three outputs above.
REQ-011 SHALL have port Error, input, 1: ALU signed-overflow indication; only meaningful for add/sub.
REQ-012 SHALL have ports ld_en (input, 1), ld_addr (input, 2) and ld_data (input, 4): direct register-file write port.
REQ-013 SHALL have ports rd_addr (input, 2) and rd_data (output, 4): combinational register-file read for debug.
REQ-014 SHALL have port done, output, 1: one-cycle pulse during WB.
REQ-015 SHALL have port z_flag, output, 1: the last written-back result was 4'h0.
REQ-016 SHALL have port ovf_flag, output, 1: sticky overflow flag.
REQ-017 SHALL have port clr_ovf, input, 1: synchronous clear of ovf_flag.

Function
REQ-018 SHALL contain a register file of 4 entries x 4 bits, r0 to r3.
REQ-019 SHALL implement a 3-state FSM: IDLE -> EXEC on instr_valid&&instr_ready; EXEC -> WB unconditionally; WB -> IDLE unconditionally.
REQ-020 SHALL, on accept, latch op into Opcode, r[rs] into ALU_In1, r[rt] into ALU_In2, and rd into an internal register, all using pre-edge register values.
REQ-021 SHALL hold ALU_In1, ALU_In2 and Opcode stable from the accept edge until the next accept edge.
REQ-022 SHALL, at the end of EXEC, capture ALU_Out into result_q and capture Error&~Opcode[1] into err_q.
REQ-023 SHALL, at the end of WB, write result_q to r[rd] and load z_flag with (result_q==4'h0).
REQ-024 SHALL assert done for exactly the WB cycle.
REQ-025 SHALL give a throughput of one instruction per 3 cycles; result is visible on rd_data in the cycle after WB.
REQ-026 SHALL set ovf_flag at the end of EXEC when err_q's input is 1; set SHALL win over a simultaneous clr_ovf.
REQ-027 SHALL make clr_ovf clear ovf_flag in any other cycle.
REQ-028 SHALL make the ld_en write take effect at the next edge in any state.
REQ-029 SHALL, on a same-cycle, same-address collision between WB write-back and ld_en, let the WB write win.
REQ-030 SHALL, when ld_en targets rs or rt in the accept cycle, latch the old value into the operand register.
REQ-031 SHALL ignore instr_valid outside IDLE, with no queuing.
REQ-032 SHALL keep instr unsampled when not accepted.
REQ-033 SHALL, when ZERO_R0=1, write a result to rd=0 as a no-op for r0, still update z_flag, and still pulse done.

Reset
REQ-034 SHALL, while rst_n=0, immediately force state IDLE and clear to 0: r0-r3, ALU_In1, ALU_In2, Opcode, result_q, err_q, done, z_flag and ovf_flag.
REQ-035 SHALL make instr_ready 1 after reset release; no accept SHALL occur while rst_n=0.
REQ-036 SHALL, on reset asserted in EXEC or WB, abort the operation with no write-back and no done pulse.

Verification
REQ-037 SHALL cover: load r1=4'h3 and r2=4'h2, then issue add r3,r1,r2 (instr=8'h36) -> done in the 2nd cycle after accept, r3=4'h5, z_flag=0, ovf_flag=0.
REQ-038 SHALL cover: r1=4'h7, r2=4'h1, add r3,r1,r2 -> r3=4'h8 and ovf_flag=1; ovf_flag stays 1 through a following xor, and clears only on clr_ovf.
REQ-039 SHALL cover: r1=4'h5, r2=4'h5, xor r3,r1,r2 (instr=8'hF6) -> r3=4'h0 and z_flag=1; a nand with operands F,F gives 0 with ovf_flag unchanged.
REQ-040 SHALL cover: instr_valid held high for 6 cycles -> exactly 2 accepts, with instr_ready low during EXEC and WB.
REQ-041 SHALL cover: ld_en to r3 with 4'hA in the same cycle as WB to r3 with 4'h5 -> r3=4'h5; with ZERO_R0=1, add r0 -> rd_data(r0) stays 4'h0 while done still pulses.
REQ-042 SHALL cover: rst_n pulsed low during EXEC -> no done, all registers 0, instr_ready=1 on the first cycle after release.
